bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 81 ++++++++
 tb/tb_bus_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with active-low request/grant lines.
// The owner may keep the bus for at most MAX_HOLD contended cycles, then it must hand over.
module bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic [3:0] m_req_,
    output logic [3:0] m_grnt_,
    output logic [1:0] owner,
    output logic [7:0] hold_cnt
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    // Returns the nearest requesting master after cur, in round-robin order.
    // If no other master is requesting, the result is cur.
    function automatic logic [1:0] rr_pick(input logic [1:0] cur, input logic [3:0] req);
        logic [1:0] idx;
        rr_pick = cur;
        // Scan from farthest to nearest so that the nearest requester wins.
        for (int i = 3; i >= 1; i--) begin
            idx = cur + 2'(i);
            if (req[idx]) begin
                rr_pick = idx;
            end else begin
                rr_pick = rr_pick;
            end
        end
    endfunction

    // Active-low one-hot grant for the given owner.
    function automatic logic [3:0] grant_of(input logic [1:0] own);
        grant_of = 4'b1111;
        grant_of[own] = 1'b0;
    endfunction

    logic [1:0] owner_q, owner_d;
    logic [3:0] grnt_q, grnt_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] req_s;
    logic [3:0] others_s;
    logic       own_req_s;

    // Next owner, grant and contention counter from the sampled requests.
    always_comb begin
        req_s     = ~m_req_;
        own_req_s = req_s[owner_q];
        others_s  = req_s & grant_of(owner_q);
        owner_d   = owner_q;
        hold_d    = 8'd0;
        if (!own_req_s) begin
            owner_d = rr_pick(owner_q, req_s);
        end else if (others_s == 4'b0000) begin
            owner_d = owner_q;
        end else if (hold_q >= HOLD_LAST) begin
            owner_d = rr_pick(owner_q, others_s);
        end else begin
            hold_d = hold_q + 8'd1;
        end
        grnt_d = grant_of(owner_d);
    end

    // State register; reset parks the bus on master 0.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            owner_q <= 2'd0;
            grnt_q  <= 4'b1110;
            hold_q  <= 8'd0;
        end else begin
            owner_q <= owner_d;
            grnt_q  <= grnt_d;
            hold_q  <= hold_d;
        end
    end

    assign owner    = owner_q;
    assign m_grnt_  = grnt_q;
    assign hold_cnt = hold_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (MAX_HOLD = 4): a vector table plus
// hand-written sequences for parking, forced rotation, glitches and async reset.
module tb_bus_arbiter;

    logic       clk;
    logic       reset_;
    logic [3:0] m_req_;
    logic [3:0] m_grnt_;
    logic [1:0] owner;
    logic [7:0] hold_cnt;

    int checks;
    int errors;

    bus_arbiter #(.MAX_HOLD(4)) dut (
        .clk      (clk),
        .reset_   (reset_),
        .m_req_   (m_req_),
        .m_grnt_  (m_grnt_),
        .owner    (owner),
        .hold_cnt (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [1:0] exp_owner;
        logic [3:0] exp_grnt;
        logic [7:0] exp_hold;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [1:0] o, input logic [3:0] g, input logic [7:0] h);
        chk({name, ".owner"}, {6'd0, owner}, {6'd0, o});
        chk({name, ".grnt"}, {4'd0, m_grnt_}, {4'd0, g});
        chk({name, ".hold"}, hold_cnt, h);
    endtask

    task automatic step(input logic [3:0] req);
        m_req_ = req;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] g_of(input logic [1:0] o);
        logic [3:0] g;
        g = 4'b1111;
        g[o] = 1'b0;
        return g;
    endfunction

    logic [1:0] rot_own[12];
    logic [7:0] rot_hold[12];

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{4'b1110, 2'd0, 4'b1110, 8'd0};  // master 0 alone
        vecs[1]  = '{4'b1101, 2'd1, 4'b1101, 8'd0};  // release handoff to 1
        vecs[2]  = '{4'b1101, 2'd1, 4'b1101, 8'd0};
        vecs[3]  = '{4'b1011, 2'd2, 4'b1011, 8'd0};
        vecs[4]  = '{4'b1010, 2'd2, 4'b1011, 8'd1};  // 0 contends with 2
        vecs[5]  = '{4'b1110, 2'd0, 4'b1110, 8'd0};  // wrap to 0
        vecs[6]  = '{4'b0111, 2'd3, 4'b0111, 8'd0};
        vecs[7]  = '{4'b1111, 2'd3, 4'b0111, 8'd0};  // parked on 3
        vecs[8]  = '{4'b0000, 2'd3, 4'b0111, 8'd1};
        vecs[9]  = '{4'b0000, 2'd3, 4'b0111, 8'd2};
        vecs[10] = '{4'b0000, 2'd3, 4'b0111, 8'd3};
        vecs[11] = '{4'b0000, 2'd0, 4'b1110, 8'd0};  // forced rotation 3 -> 0
        vecs[12] = '{4'b0000, 2'd0, 4'b1110, 8'd1};
        vecs[13] = '{4'b1111, 2'd0, 4'b1110, 8'd0};  // park on 0
        vecs[14] = '{4'b0011, 2'd2, 4'b1011, 8'd0};  // nearest of 2,3 wins
        vecs[15] = '{4'b1001, 2'd2, 4'b1011, 8'd1};
        vecs[16] = '{4'b1101, 2'd1, 4'b1101, 8'd0};

        rot_own  = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
        rot_hold = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};

        // Async reset without any clock edge.
        reset_ = 1'b1;
        m_req_ = 4'b0000;
        #1 reset_ = 1'b0;
        #1;
        chk_all("reset", 2'd0, 4'b1110, 8'd0);
        @(negedge clk);
        reset_ = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].req);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_owner, vecs[i].exp_grnt, vecs[i].exp_hold);
            if (i == 7) begin
                for (int k = 0; k < 9; k++) begin
                    step(4'b1111);
                    chk_all($sformatf("park%0d", k), 2'd3, 4'b0111, 8'd0);
                end
            end
        end

        // Forced rotation between masters 1 and 3.
        for (int k = 0; k < 8; k++) begin
            step(4'b0101);
            chk_all($sformatf("rot13_%0d", k), (k < 3 || k == 7) ? 2'd1 : 2'd3,
                    (k < 3 || k == 7) ? 4'b1101 : 4'b0111,
                    (k == 3 || k == 7) ? 8'd0 : 8'(k % 4 + 1));
        end

        // Three contenders: rotation follows plain round-robin order.
        for (int k = 0; k < 12; k++) begin
            step(4'b1000);
            chk_all($sformatf("rot3_%0d", k), rot_own[k], g_of(rot_own[k]), rot_hold[k]);
        end

        // Build up owner 2 with hold 2.
        step(4'b1011);
        chk_all("pre_own2", 2'd2, 4'b1011, 8'd0);
        step(4'b1010);
        chk_all("pre_h1", 2'd2, 4'b1011, 8'd1);

        // Glitch between edges must be ignored.
        m_req_ = 4'b1111;
        #2 m_req_ = 4'b1010;
        @(posedge clk);
        #1;
        chk_all("glitch", 2'd2, 4'b1011, 8'd2);

        // Reset pulse mid-contention, between edges.
        #2 reset_ = 1'b0;
        #1;
        chk_all("rst_mid", 2'd0, 4'b1110, 8'd0);
        #2 reset_ = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst", 2'd0, 4'b1110, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
